// File: rtl/ldl_cdc_change_fifo_v1.sv
// Change detector with a stability filter feeding a small event FIFO, placed after a handshake CDC stage.
// Optional LDL_CHG_OVERWRITE_EN: when the FIFO overflows, the oldest event is replaced instead of the newest being dropped.
module ldl_cdc_change_fifo_v1 #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] num,
    input  logic [DW-1:0] din,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   level,
    output logic          drop,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {IDLE, SETTLE} state_e;

    state_e        state_q;
    logic [DW-1:0] ref_q;
    logic [DW-1:0] cand_q;
    logic [CW-1:0] cnt_q;
    logic          commit_c;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic [AW:0]   level_q, level_d;
    logic [DW-1:0] head_q, head_d;
    logic          out_valid_q;
    logic          drop_q, drop_d;
    logic          ovf_q, ovf_d;
    logic          full_c, pop_c, wr_en_c, rd_adv_c;

    // Candidate has survived the full window and still differs from the committed value
    assign commit_c = (state_q == SETTLE) && (din != ref_q) && (din == cand_q) && (cnt_q >= num);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ref_q   <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (din != ref_q) begin
                        cand_q  <= din;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (din == ref_q) begin
                        state_q <= IDLE;
                    end else if (din != cand_q) begin
                        cand_q <= din;
                        cnt_q  <= '0;
                    end else if (cnt_q >= num) begin
                        ref_q   <= cand_q;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        full_c = (level_q == (AW+1)'(DEPTH));
        pop_c  = out_valid_q & out_ready;
        drop_d = commit_c & full_c & ~pop_c;
`ifdef LDL_CHG_OVERWRITE_EN
        wr_en_c  = commit_c;
        rd_adv_c = pop_c | drop_d;
`else
        wr_en_c  = commit_c & ~drop_d;
        rd_adv_c = pop_c;
`endif
        wr_d    = wr_en_c  ? wr_q + (AW+1)'(1) : wr_q;
        rd_d    = rd_adv_c ? rd_q + (AW+1)'(1) : rd_q;
        level_d = wr_d - rd_d;
        // A write into the slot that becomes the head must bypass the array
        if (wr_en_c && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
            head_d = cand_q;
        end else begin
            head_d = mem_q[rd_d[AW-1:0]];
        end
        ovf_d = drop_d ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q        <= '0;
            rd_q        <= '0;
            level_q     <= '0;
            head_q      <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            level_q     <= level_d;
            head_q      <= head_d;
            out_valid_q <= (level_d != '0);
            drop_q      <= drop_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_q[AW-1:0]] <= cand_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = head_q;
    assign level     = level_q;
    assign drop      = drop_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ldl_cdc_change_fifo_v1.sv
// Directed bench for ldl_cdc_change_fifo_v1: filter latency, glitch rejection, overflow, reset flush.
module tb_ldl_cdc_change_fifo_v1;

    logic       clk;
    logic       rst;
    logic [7:0] num;
    logic [7:0] din;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] level;
    logic       drop;
    logic       ovf;
    logic       ovf_clr;

    int n_vec;
    int n_err;

    ldl_cdc_change_fifo_v1 #(.DW(8), .CW(8), .AW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .num       (num),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .drop      (drop),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_q(input string tag, input logic exp_valid, input logic [2:0] exp_level,
                           input logic [7:0] exp_data);
        check({tag, "_valid"}, 32'(out_valid), 32'(exp_valid));
        check({tag, "_level"}, 32'(level), 32'(exp_level));
        if (exp_valid) check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    endtask

    // One stable change at num=0: sampled on the first edge, pushed on the second
    task automatic post(input logic [7:0] v);
        din = v;
        tick(2);
    endtask

    task automatic pop1;
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    logic [7:0] exp_head [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; num = 8'd0; din = 8'h00; out_ready = 1'b0; ovf_clr = 1'b0;
        tick(2);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // Test 1: din equal to reset ref yields nothing; first change has 2-cycle latency
        tick(6);
        check("t1_idle_valid", 32'(out_valid), 32'd0);
        din = 8'h5A;
        tick(1);
        check("t1_nofallthru", 32'(out_valid), 32'd0);
        tick(1);
        check_q("t1_event", 1'b1, 3'd1, 8'h5A);
        pop1();
        check_q("t1_drained", 1'b0, 3'd0, 8'h00);
        post(8'h00);
        check_q("t1_base00", 1'b1, 3'd1, 8'h00);
        pop1();

        // Test 2: num=3, a 3-edge glitch is rejected, a 5-edge hold commits at t+4
        num = 8'd3;
        din = 8'h11;
        tick(3);
        din = 8'h00;
        tick(4);
        check_q("t2_glitch", 1'b0, 3'd0, 8'h00);
        din = 8'h11;
        tick(4);
        check("t2_early", 32'(out_valid), 32'd0);
        tick(1);
        check_q("t2_commit", 1'b1, 3'd1, 8'h11);
        tick(3);
        check("t2_single", 32'(level), 32'd1);
        pop1();

        // Test 3: num=2, candidate restarts when 0x22 becomes 0x33
        num = 8'd2;
        din = 8'h22;
        tick(2);
        din = 8'h33;
        tick(3);
        check("t3_early", 32'(out_valid), 32'd0);
        tick(1);
        check_q("t3_commit", 1'b1, 3'd1, 8'h33);
        tick(3);
        check("t3_single", 32'(level), 32'd1);
        pop1();
        check("t3_drained", 32'(level), 32'd0);

        // Test 4: five events into a 4-deep FIFO with no consumer
        num = 8'd0;
        for (int i = 1; i <= 4; i++) post(8'(i));
        check("t4_full_level", 32'(level), 32'd4);
        check("t4_no_drop", 32'(drop), 32'd0);
        post(8'h05);
        check("t4_drop", 32'(drop), 32'd1);
        check("t4_ovf", 32'(ovf), 32'd1);
        check("t4_level", 32'(level), 32'd4);
        tick(1);
        check("t4_drop_pulse", 32'(drop), 32'd0);
`ifdef LDL_CHG_OVERWRITE_EN
        exp_head = '{8'h02, 8'h03, 8'h04, 8'h05};
`else
        exp_head = '{8'h01, 8'h02, 8'h03, 8'h04};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4_drain_data", 32'(out_data), 32'(exp_head[i]));
            check("t4_drain_level", 32'(level), 32'(4 - i));
            tick(1);
        end
        out_ready = 1'b0;
        check_q("t4_empty", 1'b0, 3'd0, 8'h00);

        // Test 5: push and pop together while full, then ovf_clr behaviour
        for (int i = 0; i < 4; i++) post(8'(8'h0A + i));
        check("t5_full", 32'(level), 32'd4);
        din = 8'h0E;
        tick(1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("t5_no_drop", 32'(drop), 32'd0);
        check_q("t5_pushpop", 1'b1, 3'd4, 8'h0B);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t5_ovf_clr", 32'(ovf), 32'd0);
        din = 8'h0F;
        tick(1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t5_drop_wins_drop", 32'(drop), 32'd1);
        check("t5_drop_wins_ovf", 32'(ovf), 32'd1);
`ifdef LDL_CHG_OVERWRITE_EN
        check_q("t5_after_ovf", 1'b1, 3'd4, 8'h0C);
`else
        check_q("t5_after_ovf", 1'b1, 3'd4, 8'h0B);
`endif

        // Test 6: reset mid-settle with 3 entries buffered
        pop1();
        check("t6_three", 32'(level), 32'd3);
        num = 8'd5;
        din = 8'h77;
        tick(2);
        rst = 1'b1;
        din = 8'h0F;
        tick(1);
        check_q("t6_reset", 1'b0, 3'd0, 8'h00);
        check("t6_ovf", 32'(ovf), 32'd0);
        check("t6_drop", 32'(drop), 32'd0);
        rst = 1'b0;
        num = 8'd0;
        tick(1);
        check("t6_early", 32'(out_valid), 32'd0);
        tick(1);
        check_q("t6_reevent", 1'b1, 3'd1, 8'h0F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
